// File: rtl/gray_switch_conditioner.sv
// gray_switch_conditioner
//   Conditions the four raw Gray-coded slide switches before the Gray-to-binary
//   decoder. Each pin is synchronised, and the 4-bit word is debounced as a
//   whole. A new word is committed only after DB_CYCLES consecutive identical
//   synchronised samples.
//
//   Build option: define GRAY_STEP_CHECK_EN to flag committed updates that
//   moved more than one switch at once. The flag is step_err. When the option
//   is not defined, step_err is tied low.
//
// Parameters
//   SYNC_STAGES  synchroniser depth per bit (2..4)
//   DB_CYCLES    identical samples needed to commit a word (>= 2)
//
// Ports
//   clk       system clock
//   rst_n     asynchronous active-low reset
//   ag..dg    raw switch pins, ag is the MSB
//   gray_q    committed Gray word {ag,bg,cg,dg}
//   upd       one-cycle pulse when gray_q takes a new, different value
//   stable    high once the first post-reset word has been committed
//   step_err  one-cycle pulse with upd on a multi-bit Gray jump
//
// State    | meaning
// ---------+--------------------------------------------------------------
// SETTLE   | after reset: wait for the first stable word, no upd pulse
// STABLE   | gray_q matches the synchronised input, idle
// COUNT    | input differs from gray_q: timing the candidate word
module gray_switch_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 270000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ag,
  input  logic       bg,
  input  logic       cg,
  input  logic       dg,
  output logic [3:0] gray_q,
  output logic       upd,
  output logic       stable,
  output logic       step_err
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    STABLE = 2'd1,
    COUNT  = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       s_word;
  logic [3:0]       cand;
  logic [CNT_W-1:0] cnt;

  // Synchroniser chain. Only s_word, the last stage, feeds any logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 4'b0000;
    end else begin
      sync_q[0] <= {ag, bg, cg, dg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_word = sync_q[SYNC_STAGES-1];

`ifdef GRAY_STEP_CHECK_EN
  function automatic logic multi_bit(input logic [3:0] d);
    return $countones(d) > 1;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= SETTLE;
      cand   <= 4'b0000;
      cnt    <= '0;
      gray_q <= 4'b0000;
      upd    <= 1'b0;
      stable <= 1'b0;
`ifdef GRAY_STEP_CHECK_EN
      step_err <= 1'b0;
`endif
    end else begin
      upd <= 1'b0;
`ifdef GRAY_STEP_CHECK_EN
      step_err <= 1'b0;
`endif
      case (state)
        SETTLE: begin
          if (s_word != cand) begin
            cand <= s_word;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            gray_q <= cand;
            stable <= 1'b1;
            state  <= STABLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (s_word != gray_q) begin
            cand  <= s_word;
            cnt   <= CNT_ONE;
            state <= COUNT;
          end
        end
        COUNT: begin
          if (s_word != cand) begin
            cand <= s_word;
            cnt  <= CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            gray_q <= cand;
            state  <= STABLE;
            // A candidate that settled back on gray_q was a rejected glitch.
            if (cand != gray_q) begin
              upd <= 1'b1;
`ifdef GRAY_STEP_CHECK_EN
              step_err <= multi_bit(cand ^ gray_q);
`endif
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= SETTLE;
      endcase
    end
  end

`ifndef GRAY_STEP_CHECK_EN
  assign step_err = 1'b0;
`endif

endmodule
